spike_rate_monitor: RTL and testbench

//  Downstream consumer of a neuron's 1-bit spike output. Counts spikes over a

---
 rtl/spike_mon_pkg.sv | 13 +
 rtl/sat_counter.sv | 37 +++
 rtl/spike_rate_monitor.sv | 147 ++++++++++++++
 tb/tb_spike_rate_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_mon_pkg.sv
// Shared types and constants for the spike rate monitor.
package spike_mon_pkg;

  typedef enum logic [0:0] {StIdle, StCount} mon_state_e;

  localparam int unsigned WIN_W_DEF   = 8;
  localparam int unsigned COUNT_W_DEF = 6;
  localparam int unsigned ISI_W_DEF   = 8;

  localparam logic [COUNT_W_DEF-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W_DEF-1:0]   ISI_NONE = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         saturated
);

  logic [W-1:0] count_q, count_d;

  assign count     = count_q;
  assign saturated = (count_q == '1);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && !saturated) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts spikes and tracks minimum inter-spike interval over programmable windows,
// publishing each window result through a valid/ready output register.
module spike_rate_monitor
  import spike_mon_pkg::*;
#(
  parameter int unsigned WIN_W   = WIN_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF,
  parameter int unsigned ISI_W   = ISI_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spike,
  input  logic [WIN_W-1:0]   window_len,
  output logic [COUNT_W-1:0] out_count,
  output logic [ISI_W-1:0]   out_isi_min,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
);

  mon_state_e         state_q, state_d;
  logic [WIN_W-1:0]   len_q, len_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [ISI_W-1:0]   acc_min_q, acc_min_d, acc_min_upd;
  logic [COUNT_W-1:0] acc_count, win_count;
  logic               acc_sat;
  logic [ISI_W-1:0]   gap;
  logic               gap_sat;
  logic               count_spike, win_last, win_begin;

  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic [ISI_W-1:0]   out_isi_q, out_isi_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  assign count_spike = spike && (state_q == StCount);
  assign win_last    = (state_q == StCount) && (win_cnt_q == len_q - WIN_W'(1));
  assign win_begin   = (window_len != '0) && ((state_q == StIdle) || win_last);

  // A saturated gap means no spike since reset (or too long ago to matter).
  assign acc_min_upd = (count_spike && !gap_sat && (gap < acc_min_q)) ? gap : acc_min_q;
  // Window total including a spike on the closing cycle.
  assign win_count   = (count_spike && !acc_sat) ? acc_count + COUNT_W'(1) : acc_count;

  sat_counter #(
    .W         (COUNT_W),
    .RESET_VAL ('0)
  ) u_acc_count (
    .clk       (clk),
    .reset     (reset),
    .load      (win_begin),
    .load_val  ('0),
    .inc       (count_spike),
    .count     (acc_count),
    .saturated (acc_sat)
  );

  sat_counter #(
    .W         (ISI_W),
    .RESET_VAL ('1)
  ) u_gap (
    .clk       (clk),
    .reset     (reset),
    .load      (spike),
    .load_val  (ISI_W'(1)),
    .inc       (1'b1),
    .count     (gap),
    .saturated (gap_sat)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    win_cnt_d = win_cnt_q;
    acc_min_d = acc_min_upd;
    unique case (state_q)
      StIdle: begin
        if (window_len != '0) begin
          state_d   = StCount;
          len_d     = window_len;
          win_cnt_d = '0;
          acc_min_d = '1;
        end
      end
      StCount: begin
        if (win_last) begin
          win_cnt_d = '0;
          acc_min_d = '1;
          if (window_len == '0) begin
            state_d = StIdle;
          end else begin
            len_d = window_len;
          end
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_count_d = out_count_q;
    out_isi_d   = out_isi_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (win_last) begin
      if (!out_valid_q || out_ready) begin
        out_count_d = win_count;
        out_isi_d   = acc_min_upd;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      win_cnt_q   <= '0;
      acc_min_q   <= '1;
      out_count_q <= '0;
      out_isi_q   <= '1;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      win_cnt_q   <= win_cnt_d;
      acc_min_q   <= acc_min_d;
      out_count_q <= out_count_d;
      out_isi_q   <= out_isi_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_count   = out_count_q;
  assign out_isi_min = out_isi_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor against a time-stamp based reference model.
module tb_spike_rate_monitor;
  import spike_mon_pkg::*;

  logic       clk, reset, spike, out_ready, out_valid, overrun;
  logic [7:0] window_len, out_isi_min;
  logic [5:0] out_count;
  logic [15:0] got;

  int nvec, nerr;

  // Reference model: windows described by start time and length, ISIs from spike times.
  int m_t, m_last, m_start, m_len, m_spk, m_min, m_oc, m_oi;
  bit m_act, m_ov, m_ovr;

  assign got = {out_valid, out_count, out_isi_min, overrun};

  spike_rate_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .spike       (spike),
    .window_len  (window_len),
    .out_count   (out_count),
    .out_isi_min (out_isi_min),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_vec();
    return {m_ov, 6'(m_oc), 8'(m_oi), m_ovr};
  endfunction

  task automatic model_reset();
    m_t = 0; m_last = -1; m_act = 0; m_start = 0; m_len = 0; m_spk = 0; m_min = 255;
    m_ov = 0; m_oc = 0; m_oi = 255; m_ovr = 0;
  endtask

  task automatic model_step(input bit s, input int wl, input bit rdy);
    bit closed;
    closed = 0;
    if (!m_act) begin
      if (wl != 0) begin
        m_act = 1; m_start = m_t + 1; m_len = wl; m_spk = 0; m_min = 255;
      end
    end else begin
      if (s) begin
        m_spk++;
        if (m_last >= 0 && (m_t - m_last) < 255 && (m_t - m_last) < m_min) m_min = m_t - m_last;
      end
      if (m_t - m_start == m_len - 1) begin
        closed = 1;
        if (!m_ov || rdy) begin
          m_ov = 1; m_oc = (m_spk > 63) ? 63 : m_spk; m_oi = m_min;
        end else begin
          m_ovr = 1;
        end
        if (wl != 0) begin
          m_start = m_t + 1; m_len = wl; m_spk = 0; m_min = 255;
        end else begin
          m_act = 0;
        end
      end
    end
    if (!closed && m_ov && rdy) m_ov = 0;
    if (s) m_last = m_t;
    m_t++;
  endtask

  task automatic step(input bit s, input int wl, input bit rdy);
    spike = s; window_len = wl[7:0]; out_ready = rdy;
    model_step(s, wl, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; spike = 1'b0; window_len = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; spike = 1'b0; window_len = '0; out_ready = 1'b0;
    model_reset();
    #2;
    nvec++;
    if (got !== {1'b0, 6'd0, ISI_NONE, 1'b0}) begin
      nerr++; $display("FAIL reset_values got=%h exp=%h", got, {1'b0, 6'd0, ISI_NONE, 1'b0});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    nvec++;
    if (got !== exp_vec()) begin
      nerr++; $display("FAIL reset_release got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_basic_window();
    step(0, 10, 1);
    for (int k = 0; k < 10; k++) begin
      step(k == 2 || k == 5 || k == 6, (k == 9) ? 0 : 10, 1);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL basic_window k=%0d got=%h exp=%h", k, got, exp_vec());
      end
    end
    nvec++;
    if (got[15:1] !== {1'b1, 6'd3, 8'd1}) begin
      nerr++; $display("FAIL basic_result got=%h exp=%h", got[15:1], {1'b1, 6'd3, 8'd1});
    end
  endtask

  task automatic test_back_to_back();
    step(0, 4, 1);
    for (int k = 0; k < 12; k++) begin
      step(0, (k == 11) ? 0 : 4, 1);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp_vec());
      end
      nvec++;
      if ((k % 4) == 3) begin
        if (got[15:1] !== {1'b1, 6'd0, 8'hFF}) begin
          nerr++; $display("FAIL empty_window k=%0d got=%h exp=%h", k, got[15:1], {1'b1, 6'd0, 8'hFF});
        end
      end else if (out_valid !== 1'b0) begin
        nerr++; $display("FAIL no_valid_mid k=%0d got=%b exp=0", k, out_valid);
      end
    end
  endtask

  task automatic test_saturate();
    step(1, 100, 1);
    for (int k = 0; k < 100; k++) begin
      step(1, (k == 99) ? 0 : 100, 1);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL saturate k=%0d got=%h exp=%h", k, got, exp_vec());
      end
    end
    nvec++;
    if (got[15:1] !== {1'b1, CNT_MAX, 8'd1}) begin
      nerr++; $display("FAIL saturate_result got=%h exp=%h", got[15:1], {1'b1, CNT_MAX, 8'd1});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    step(0, 5, 0);
    for (int k = 0; k < 10; k++) begin
      step(k == 0 || k == 3 || (k >= 5 && k <= 8), (k == 9) ? 0 : 5, 0);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL overrun k=%0d got=%h exp=%h", k, got, exp_vec());
      end
    end
    nvec++;
    if (got !== {1'b1, 6'd2, 8'd3, 1'b1}) begin
      nerr++; $display("FAIL overrun_hold got=%h exp=%h", got, {1'b1, 6'd2, 8'd3, 1'b1});
    end
    step(0, 0, 1);
    nvec++;
    if (got !== {1'b0, 6'd2, 8'd3, 1'b1}) begin
      nerr++; $display("FAIL overrun_drain got=%h exp=%h", got, {1'b0, 6'd2, 8'd3, 1'b1});
    end
    // Close coinciding with a handshake must load the new result without overrun.
    do_reset();
    step(0, 3, 0);
    for (int k = 0; k < 6; k++) begin
      step(k == 1 || k == 4 || k == 5, (k == 5) ? 0 : 3, k == 5);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL close_handshake k=%0d got=%h exp=%h", k, got, exp_vec());
      end
    end
    nvec++;
    if (got !== {1'b1, 6'd2, 8'd1, 1'b0}) begin
      nerr++; $display("FAIL close_handshake_result got=%h exp=%h", got, {1'b1, 6'd2, 8'd1, 1'b0});
    end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    step(0, 8, 0);
    for (int k = 0; k < 11; k++) begin
      step(k == 1 || k == 2 || k == 8 || k == 9, 8, 0);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, got, exp_vec());
      end
    end
    reset = 1'b1;
    #1;
    model_reset();
    nvec++;
    if (got !== {1'b0, 6'd0, 8'hFF, 1'b0}) begin
      nerr++; $display("FAIL async_reset got=%h exp=%h", got, {1'b0, 6'd0, 8'hFF, 1'b0});
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, got, exp_vec());
      end
    end
  endtask

  task automatic test_len_change();
    do_reset();
    step(0, 8, 1);
    for (int k = 0; k < 16; k++) begin
      step(k == 2 || k == 9, (k < 3) ? 8 : ((k < 10) ? 3 : 0), 1);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL len_change k=%0d got=%h exp=%h", k, got, exp_vec());
      end
      if (k == 7 || k == 10) begin
        nvec++;
        if (got[15:1] !== {1'b1, 6'd1, (k == 7) ? 8'hFF : 8'd7}) begin
          nerr++; $display("FAIL len_change_close k=%0d got=%h", k, got[15:1]);
        end
      end else begin
        nvec++;
        if (out_valid !== 1'b0) begin
          nerr++; $display("FAIL len_change_idle k=%0d got=%b exp=0", k, out_valid);
        end
      end
    end
  endtask

  task automatic test_random();
    int wl;
    bit s;
    do_reset();
    wl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) wl = ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 12));
      if ((i / 500) % 2 == 1) s = ($urandom % 200 == 0);
      else s = ($urandom % 3 == 0);
      step(s, wl, ($urandom % 3) != 0);
      nvec++;
      if (got !== exp_vec()) begin
        nerr++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_basic_window();
    test_back_to_back();
    test_saturate();
    test_overrun();
    test_reset_mid_window();
    test_len_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
